// File: rtl/fp32_round_cvt_if.sv
// Valid/ready bundle between an fp32 producer and the reduced-precision converter.
// Latency: none, wiring only; carries both the input and the output handshake.
// Backpressure: in_ready/out_ready travel opposite to their valid signals.
interface fp32_round_cvt_if #(
  parameter int MANT_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [8+MANT_W:0] out_data;
  logic              out_ovf;

  // Producer and consumer side, as seen from outside the converter.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  // Converter side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/fp32_round_cvt.sv
// Converts IEEE fp32 to {sign, exp8, MANT_W mantissa}; RNE when FP32_ROUND_CVT_RNE_EN is defined, else truncation.
// Latency: 2 cycles, S1 = decoded fields + round/sticky, S2 = rounded result; 1 item/cycle sustained.
// Backpressure: S2 holds while out_ready is low, S1 fills behind it, then in_ready drops (2 items max).
module fp32_round_cvt #(
  parameter int MANT_W = 9
) (
  input logic              clk,
  input logic              rst,
  fp32_round_cvt_if.slave  bus
);
  localparam int OUT_W   = 9 + MANT_W;
  localparam int RND_IDX = 22 - MANT_W;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
`ifdef FP32_ROUND_CVT_RNE_EN
    logic              rnd;
    logic              stk;
`endif
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } s1_t;

  logic             s1_vld;
  logic             s2_vld;
  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;
  s1_t              s1_d;
  s1_t              s1_q;
  logic             inc;
  logic [MANT_W:0]  mant_sum;
  logic [7:0]       exp_sum;
  logic [MANT_W-1:0] nan_mant;
  logic [OUT_W-1:0] res_dat;
  logic             res_ovf;
  logic [OUT_W-1:0] out_dat_q;
  logic             out_ovf_q;

  // S2 moves when empty or drained; S1 moves when S2 takes its item or S1 is empty.
  assign s2_adv  = !s2_vld || bus.out_ready;
  assign s1_adv  = s2_adv || !s1_vld;
  assign in_fire = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_vld || s1_adv;
  assign bus.out_valid = s2_vld;
  assign bus.out_data  = out_dat_q;
  assign bus.out_ovf   = out_ovf_q;

  // Split the fp32 operand into kept mantissa, rounding bits and class flags.
  always_comb begin
    s1_d         = '0;
    s1_d.sign    = bus.in_data[31];
    s1_d.exp     = bus.in_data[30:23];
    s1_d.mant    = bus.in_data[22 -: MANT_W];
`ifdef FP32_ROUND_CVT_RNE_EN
    s1_d.rnd     = bus.in_data[RND_IDX];
    s1_d.stk     = |bus.in_data[RND_IDX-1:0];
`endif
    s1_d.is_zero = (bus.in_data[30:23] == 8'h00);
    s1_d.is_inf  = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] == 23'd0);
    s1_d.is_nan  = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
  end

  // Round the S1 mantissa and resolve special cases into the packed result.
  always_comb begin
`ifdef FP32_ROUND_CVT_RNE_EN
    inc = s1_q.rnd && (s1_q.stk || s1_q.mant[0]);
`else
    inc = 1'b0;
`endif
    // A carry out of the mantissa leaves the low bits at zero and bumps the exponent;
    // finite exponents top out at 254 so the 8-bit sum cannot wrap.
    mant_sum = {1'b0, s1_q.mant} + {{MANT_W{1'b0}}, inc};
    exp_sum  = s1_q.exp + {7'd0, mant_sum[MANT_W]};
    nan_mant = s1_q.mant;
    nan_mant[MANT_W-1] = 1'b1;
    res_ovf  = 1'b0;
    res_dat  = {s1_q.sign, exp_sum, mant_sum[MANT_W-1:0]};
    if (s1_q.is_zero) begin
      res_dat = {s1_q.sign, 8'h00, {MANT_W{1'b0}}};
    end else if (s1_q.is_nan) begin
      res_dat = {s1_q.sign, 8'hFF, nan_mant};
    end else if (s1_q.is_inf) begin
      res_dat = {s1_q.sign, 8'hFF, {MANT_W{1'b0}}};
`ifdef FP32_ROUND_CVT_RNE_EN
    end else if (exp_sum == 8'hFF) begin
      res_dat = {s1_q.sign, 8'hFF, {MANT_W{1'b0}}};
      res_ovf = 1'b1;
`endif
    end
  end

  // Stage valid flags; cleared asynchronously so in-flight items vanish on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (s1_adv) s1_vld <= bus.in_valid;
      if (s2_adv) s2_vld <= s1_vld;
    end
  end

  // S1 datapath captures only accepted operands and is left unreset.
  always_ff @(posedge clk) begin
    if (in_fire) s1_q <= s1_d;
  end

  // S2 result register; reset because it is directly visible on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_dat_q <= '0;
      out_ovf_q <= 1'b0;
    end else if (s2_adv && s1_vld) begin
      out_dat_q <= res_dat;
      out_ovf_q <= res_ovf;
    end
  end
endmodule

// File: doc/fp32_round_cvt.md
FP32_ROUND_CVT -- requirements
Module: fp32_round_cvt

Interface
REQ-001 SHALL have parameter MANT_W, default 9, giving the output mantissa width (9 = cherry_float, 10 = tf32, 7 = bf16).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  32  IEEE fp32 operand.
REQ-007 SHALL have port out_valid  output  1  out_data is valid.
REQ-008 SHALL have port out_ready  input  1  consumer (Mul operand register) accepts out_data.
REQ-009 SHALL have port out_data  output  9+MANT_W  {sign, 8-bit exp, MANT_W mantissa}.
REQ-010 SHALL have port out_ovf  output  1  finite input rounded to infinity; qualified by out_valid.

Function
REQ-011 SHALL move data over valid/ready: transfer occurs on a rising edge when valid && ready are both high.
REQ-012 SHALL be a 2-stage pipeline: S1 registers the decoded fields and round/sticky bits; S2 registers the rounded result.
REQ-013 SHALL present the result with out_valid high 2 cycles after input acceptance when out_ready stays high.
REQ-014 SHALL sustain 1 transfer/cycle with out_ready high and no bubbles.
REQ-015 SHALL advance S2 when it is empty or out_ready is high; S1 SHALL advance when S2 advances or S1 is empty.
REQ-016 SHALL drive in_ready = !S1_valid || S1_advance (combinational from out_ready; no path from in_valid).
REQ-017 SHALL, under backpressure, hold at most 2 items; no loss, duplication or reordering.
REQ-018 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL keep in_data[22 -: MANT_W] as the mantissa, with round bit = in_data[22-MANT_W] and sticky = OR of in_data[21-MANT_W:0].
REQ-020 SHALL apply the rounding of REQ-031/032; a mantissa carry-out SHALL increment the exponent and zero the mantissa.
REQ-021 SHALL, when rounding raises the exponent to 255 from a finite input, output signed infinity (mantissa 0) and set out_ovf=1.
REQ-022 SHALL pass infinity (exp=255, mant=0) through unchanged with out_ovf=0.
REQ-023 SHALL output NaN for NaN input (exp=255, mant≠0): sign kept, exp 255, kept mantissa bits with MSB forced to 1; out_ovf=0.
REQ-024 SHALL flush input exp=0 (zero/denormal) to signed zero.
REQ-025 SHALL ignore in_data whenever in_valid is low.

Reset
REQ-026 SHALL clear S1_valid and S2_valid immediately on rst assertion, independent of clk.
REQ-027 SHALL output out_valid=0, out_ovf=0, out_data=0 during reset; in_ready SHALL be 1 during and after reset.
REQ-028 SHALL discard in-flight items when reset is asserted mid-operation; nothing from them appears after release.
REQ-029 SHALL accept a transfer on the first rising edge after rst deasserts.
REQ-030 SHALL not reset datapath registers other than the output-visible values listed in REQ-027.

Configuration
REQ-031 SHALL, with FP32_ROUND_CVT_RNE_EN defined, round to nearest, ties to even: increment if round && (sticky || kept LSB).
REQ-032 SHALL, without FP32_ROUND_CVT_RNE_EN, truncate (no increment); out_ovf is then constant 0 and latency is unchanged.

Verification (MANT_W=9, RNE_EN defined unless stated)
REQ-033 SHALL check 3F800000 -> 0FE00; 3F802000 (tie, even) -> 0FE00; 3F806000 (tie, odd) -> 0FE02; 3F802001 -> 0FE01; each 2 cycles after accept.
REQ-034 SHALL check 7F7FFFFF -> 1FE00 with out_ovf=1; with RNE_EN undefined -> 1FDFF with out_ovf=0; 3F806000 -> 0FE01.
REQ-035 SHALL check 7F800001 -> 1FF00 (quiet NaN); FF800000 -> 3FE00 (out_ovf=0); 80000001 -> 20000.
REQ-036 SHALL check backpressure: out_ready=0 while offering 3F800000, 40000000, 40400000 -> first two accepted, in_ready=0 on the third, out_data held stable; then out_ready=1 -> outputs 0FE00, 10000, 10100 in order, the third emitted after accept.
REQ-037 SHALL check mid-operation reset: 2 items in flight, rst pulsed between clk edges -> out_valid=0 at once, no stale output after release, the next input is returned correctly 2 cycles after accept.
